// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   opnd, a_orig;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem, res_hi, res_lo;
    logic [WIDTH:0]     add_sum, rem_sh, rem_diff;

    // Signed ops run on magnitudes; signs are reapplied in FIX.
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!rem_diff[WIDTH])
                acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_wr) hi <= wdata;
                    if (lo_wr) lo <= wdata;
                    if (start) begin
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        a_orig   <= a;
                        div_zero <= (b == '0);
                        opnd     <= op[1] ? b_abs : a_abs;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
